// File: rtl/mb_seq_multiplier_pkg.sv
// Shared types and constants for the sequential radix-4 Modified Booth multiplier.
// Optional build macro used by the top module: MB_SEQ_EARLY_DONE_EN.
package mb_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mb_state_e;

  // Default operand width (even, >= 4)
  localparam int unsigned MB_N = 8;

  // Width of the digit counter for an N-bit operand (N/2 digits)
  function automatic int unsigned mb_cnt_w(input int unsigned n);
    return (n / 2 > 1) ? $clog2(n / 2) : 1;
  endfunction

  localparam int unsigned MB_CNT_W = mb_cnt_w(MB_N);

  // One Modified Booth digit: magnitude select (one/two) plus sign
  typedef struct packed {
    logic sign;
    logic one;
    logic two;
  } mb_digit_t;

endpackage

// File: rtl/mb_seq_multiplier_if.sv
// Start/done handshake and operand/product bus of the sequential MB multiplier.
interface mb_seq_multiplier_if
  import mb_pkg::*;
#(
  parameter int unsigned N = MB_N
) ();

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, b,
    input  ready, busy, done, p
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, p
  );

endinterface

// File: rtl/mb_pp_select.sv
// Combinational MB digit encoder and partial-product selector: triplet + A -> 0/+-A/+-2A,
// sign-extended to 2N bits, not yet shifted into digit position.
module mb_pp_select
  import mb_pkg::*;
#(
  parameter int unsigned N = MB_N
) (
  input  logic [2:0]     triplet,
  input  logic [N-1:0]   a,
  output logic [2*N-1:0] pp
);

  mb_digit_t      digit;
  logic           bjp, bjz, bjm;
  logic [2*N-1:0] a_ext;
  logic [2*N-1:0] mag;

  // Encode the triplet and pick the signed multiple of A
  always_comb begin
    bjp        = triplet[2];
    bjz        = triplet[1];
    bjm        = triplet[0];
    digit.sign = bjp & ~(bjp & bjz & bjm);
    digit.one  = bjm ^ bjz;
    digit.two  = ~digit.one & (bjp ^ bjz);
    a_ext      = {{N{a[N-1]}}, a};
    mag        = '0;
    if (digit.one) begin
      mag = a_ext;
    end else if (digit.two) begin
      mag = a_ext << 1;
    end
    pp = digit.sign ? (-mag) : mag;
  end

endmodule

// File: rtl/mb_seq_multiplier.sv
// Sequential radix-4 Modified Booth multiplier: one MB digit per clock, start/done handshake.
// Build option: define MB_SEQ_EARLY_DONE_EN to finish as soon as the remaining
// multiplier digits all encode zero.
module mb_seq_multiplier
  import mb_pkg::*;
#(
  parameter int unsigned N = MB_N
) (
  input  logic                clk,
  input  logic                rst,
  mb_seq_multiplier_if.slave  bus
);

  localparam int unsigned CW = mb_cnt_w(N);

  mb_state_e      state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N:0]     b_ext;
  logic [N:0]     b_sh;
  logic [CW:0]    shamt;
  logic [2:0]     triplet;
  logic [2*N-1:0] pp;
  logic [2*N-1:0] pp_shift;
  logic [2*N-1:0] acc_sum;
  logic           last_digit;
  logic           finish;
  logic           accept;
`ifdef MB_SEQ_EARLY_DONE_EN
  logic [CW+1:0]  rest_sh;
  logic [N-1:0]   b_rest;
  logic           early;
`endif

  mb_pp_select #(.N(N)) u_pp_select (
    .triplet (triplet),
    .a       (a_q),
    .pp      (pp)
  );

  // Digit extraction, shifted partial product and termination condition
  always_comb begin
    shamt      = {cnt_q, 1'b0};
    b_ext      = {b_q, 1'b0};
    b_sh       = b_ext >> shamt;
    triplet    = b_sh[2:0];
    pp_shift   = pp << shamt;
    acc_sum    = acc_q + pp_shift;
    last_digit = (cnt_q == CW'(N / 2 - 1));
`ifdef MB_SEQ_EARLY_DONE_EN
    // b[N-1:2i+1] all-equal means every later triplet is 000 or 111
    rest_sh    = (CW + 2)'(shamt) + (CW + 2)'(1);
    b_rest     = $signed(b_q) >>> rest_sh;
    early      = (b_rest == '0) || (b_rest == '1);
    finish     = last_digit || early;
`else
    finish     = last_digit;
`endif
    accept     = (state_q != RUN) && bus.start;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (finish)    state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, digit counter, accumulator and product update
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    if (accept) begin
      a_d   = bus.a;
      b_d   = bus.b;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + CW'(1);
      if (finish) begin
        p_d = acc_sum;
      end
    end
  end

  // Registered handshake outputs derived from the upcoming state
  always_comb begin
    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.p     = p_q;

endmodule

// File: tb/tb_mb_seq_multiplier.sv
// Self-checking bench for mb_seq_multiplier (N=8) against a cycle-level behavioural model.
module tb_mb_seq_multiplier;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mb_seq_multiplier_if #(.N(N)) bus ();

  mb_seq_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] exp_p;
    int          acc;
    int          lat;
    bit          spc;
  } op_t;

  op_t         q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          last_done = -100;
  logic [15:0] p_hold = '0;
  bit          exp_busy, exp_done;
  int          el;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Signed reference product modulo 2^16
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return 16'(pa * pb);
  endfunction

  // RUN cycles needed: with early finish, the fewest digits i+1 such that b fits
  // in a (2i+2)-bit signed number; otherwise always N/2
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MB_SEQ_EARLY_DONE_EN
    int v, lim;
    v = $signed(b);
    for (int i = 0; i < N / 2; i++) begin
      lim = 1 << (2 * i + 1);
      if (v >= -lim && v < lim) return i + 1;
    end
    return N / 2;
`else
    return N / 2;
`endif
  endfunction

  // Cycle-by-cycle compare against the model's outstanding operation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_p", bus.p, 0);
        q.delete();
        p_hold = '0;
      end else begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (q.size() != 0) begin
          el       = cyc - q[0].acc;
          exp_busy = (el < q[0].lat);
          exp_done = (el == q[0].lat);
        end
        chk("busy", bus.busy, exp_busy);
        chk("ready", bus.ready, !exp_busy);
        chk("done", bus.done, exp_done);
        if (bus.done) n_done++;
        if (exp_done) begin
          p_hold = q[0].exp_p;
          if (q[0].spc) chk("b2b_spacing", cyc - last_done, q[0].lat + 1);
          last_done = cyc;
          void'(q.pop_front());
        end
        chk("p", bus.p, p_hold);
      end
    end
  end

  // Wait until the model says the DUT can accept, toggling start randomly meanwhile
  // (must be ignored), then present one operation for one edge
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep, input bit spc);
    int w;
    w = 0;
    @(negedge clk);
    while (q.size() != 0 && w < 100) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      w++;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_ready: still busy after %0d cycles, expected idle", w);
      q.delete();
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    q.push_back('{ep, cyc + 1, exp_lat(b), spc});
    n_acc++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  logic [7:0] ra, rb;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Hand-computed pins on the model
    chk("pin_3x5", ref_prod(8'd3, 8'd5), 16'h000F);
    chk("pin_m128sq", ref_prod(8'h80, 8'h80), 16'h4000);
    chk("pin_7fxff", ref_prod(8'h7F, 8'hFF), 16'hFF81);
    chk("pin_m5x7", ref_prod(8'hFB, 8'h07), 16'hFFDD);
    chk("pin_2xm3", ref_prod(8'h02, 8'hFD), 16'hFFFA);
`ifdef MB_SEQ_EARLY_DONE_EN
    chk("pin_lat_ff", exp_lat(8'hFF), 1);
`else
    chk("pin_lat_ff", exp_lat(8'hFF), 4);
`endif

    // Directed operations with literal expected products
    run_op(8'd3, 8'd5, 16'h000F, 1'b0);    idle(6);
    run_op(8'h80, 8'h80, 16'h4000, 1'b0);  idle(6);
    run_op(8'h7F, 8'hFF, 16'hFF81, 1'b0);  idle(6);
    run_op(8'hFB, 8'h07, 16'hFFDD, 1'b0);
    run_op(8'h02, 8'hFD, 16'hFFFA, 1'b1);  idle(6);

    // Reset during the second RUN cycle aborts the operation
    run_op(8'd10, 8'd10, ref_prod(8'd10, 8'd10), 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_acc--;
    run_op(8'd6, 8'd6, 16'h0024, 1'b0);    idle(6);

    // Random pairs with random gaps
    repeat (2000) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_prod(ra, rb), 1'b0);
      idle($urandom_range(0, 2));
    end

    // Back-to-back sweep: every b against a spread of a values
    for (int ia = 0; ia < 19; ia++) begin
      ra = (ia == 16) ? 8'h80 : (ia == 17) ? 8'h7F : (ia == 18) ? 8'h01 : 8'(ia * 17);
      for (int ib = 0; ib < 256; ib++) begin
        rb = 8'(ib);
        run_op(ra, rb, ref_prod(ra, rb), 1'b0);
      end
    end

    idle(12);
    chk("done_count", n_done, n_acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
